// File: rtl/grid_row_packer.sv
// Packs an ASCII grid ('@'=1) into TX_DATA_WIDTH-bit row chunks and writes each one to memory.
// Accepts up to 1 byte/cycle; every write stalls input until mem_ack then mem_busy low (>=2 cycles).
module grid_row_packer #(
    parameter int TX_DATA_WIDTH   = 16,
    parameter int MAX_COLS        = 140,
    parameter int MAX_ROWS        = 140,
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int COL_ADDR_WIDTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       wr_en,
    output logic [BANK_ADDR_WIDTH-1:0] wr_row,
    output logic [COL_ADDR_WIDTH-1:0]  wr_col,
    output logic [TX_DATA_WIDTH-1:0]   wr_vec,
    input  logic                       mem_ack,
    input  logic                       mem_busy,
    output logic                       done,
    output logic                       error,
    output logic [BANK_ADDR_WIDTH-1:0] rows_written
);
    localparam int LW = $clog2(TX_DATA_WIDTH);
    localparam int CW = $clog2(MAX_COLS + 1);

    typedef enum logic [1:0] {S_ACCEPT, S_WRITE, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic [BANK_ADDR_WIDTH-1:0] row_q, row_d;
    logic [TX_DATA_WIDTH-1:0]   vec_q, vec_d;
    logic                       eof_q, eof_d;
    logic                       row_end_q, row_end_d;
    logic                       error_q, error_d;
    logic                       in_ready_q, in_ready_d;
    logic                       wr_en_q, wr_en_d;
    logic                       done_q, done_d;
    logic [BANK_ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [COL_ADDR_WIDTH-1:0]  wr_col_q, wr_col_d;
    logic [TX_DATA_WIDTH-1:0]   wr_vec_q, wr_vec_d;

    logic                       is_nl, is_data, drop, fresh, end_row, just_full, flush;
    logic [CW-1:0]              col_new, base;
    logic [TX_DATA_WIDTH-1:0]   vec_new;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        vec_d      = vec_q;
        eof_d      = eof_q;
        row_end_d  = row_end_q;
        error_d    = error_q;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_vec_d   = wr_vec_q;

        is_nl   = (in_data == 8'd10);
        is_data = !is_nl && (in_data != 8'd13);
        drop    = is_data && ((row_q == BANK_ADDR_WIDTH'(MAX_ROWS)) || (col_q == CW'(MAX_COLS)));
        fresh   = is_data && !drop;
        end_row = is_nl || in_last;

        col_new = col_q;
        vec_new = vec_q;
        if (fresh) begin
            vec_new[col_q[LW-1:0]] = (in_data == 8'h40);
            col_new                = col_q + 1'b1;
        end
        just_full = fresh && (col_new[LW-1:0] == '0);
        // A chunk goes out when it just filled, or when the row ends with a partial chunk pending.
        flush = (col_new != '0) && (just_full || (end_row && (col_new[LW-1:0] != '0)));
        base  = just_full ? (col_new - CW'(TX_DATA_WIDTH)) : {col_new[CW-1:LW], {LW{1'b0}}};

        case (state_q)
            S_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    col_d   = col_new;
                    vec_d   = vec_new;
                    eof_d   = in_last;
                    error_d = error_q | drop;
                    if (flush) begin
                        state_d   = S_WRITE;
                        wr_row_d  = row_q;
                        wr_col_d  = COL_ADDR_WIDTH'(base);
                        wr_vec_d  = vec_new;
                        vec_d     = '0;
                        row_end_d = end_row;
                    end
                    if (end_row) begin
                        col_d = '0;
                        vec_d = '0;
                        // Row ended on a chunk boundary: nothing left to write, count it now.
                        if (!flush) begin
                            if (col_new != '0) row_d = row_q + 1'b1;
                            if (in_last) state_d = S_DONE;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    state_d   = S_DRAIN;
                    row_end_d = 1'b0;
                    if (row_end_q) row_d = row_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!mem_busy) state_d = eof_q ? S_DONE : S_ACCEPT;
            end
            default: state_d = S_DONE;
        endcase

        in_ready_d = (state_d == S_ACCEPT);
        wr_en_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_ACCEPT;
            col_q      <= '0;
            row_q      <= '0;
            vec_q      <= '0;
            eof_q      <= 1'b0;
            row_end_q  <= 1'b0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_vec_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            vec_q      <= vec_d;
            eof_q      <= eof_d;
            row_end_q  <= row_end_d;
            error_q    <= error_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_vec_q   <= wr_vec_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_row       = wr_row_q;
    assign wr_col       = wr_col_q;
    assign wr_vec       = wr_vec_q;
    assign done         = done_q;
    assign error        = error_q;
    assign rows_written = row_q;
endmodule

// File: tb/tb_grid_row_packer.sv
// Directed bench for grid_row_packer with a small ack/busy memory model that logs committed writes.
module tb_grid_row_packer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        in_ready, wr_en, done, error;
    logic [7:0]  wr_row, wr_col, rows_written;
    logic [15:0] wr_vec;
    logic        mem_ack = 1'b0;
    logic        mem_busy = 1'b0;

    grid_row_packer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_vec(wr_vec),
        .mem_ack(mem_ack), .mem_busy(mem_busy),
        .done(done), .error(error), .rows_written(rows_written)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    int ack_dly = 1;
    int busy_len = 0;
    bit ack_en = 1'b1;
    bit stuck = 1'b0;
    int wr_cyc = 0;
    int busy_cnt = 0;
    int stab_err = 0;
    int rdy_err = 0;
    logic [7:0]  cap_row, cap_col;
    logic [15:0] cap_vec;
    logic [7:0]  q_row[$];
    logic [7:0]  q_col[$];
    logic [15:0] q_vec[$];
    int          q_len[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory model: acks after ack_dly cycles of wr_en, then holds busy for busy_len cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                mem_ack = 1'b0; mem_busy = 1'b0; busy_cnt = 0; wr_cyc = 0;
            end else if (mem_ack) begin
                mem_ack  = 1'b0;
                busy_cnt = busy_len;
                mem_busy = (busy_len > 0);
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                mem_busy = (busy_cnt > 0);
            end else if (wr_en) begin
                if (wr_cyc == 0) begin
                    cap_row = wr_row; cap_col = wr_col; cap_vec = wr_vec;
                end else if (wr_row !== cap_row || wr_col !== cap_col || wr_vec !== cap_vec) begin
                    stab_err++;
                end
                wr_cyc++;
                if (ack_en && wr_cyc >= ack_dly) begin
                    mem_ack = 1'b1;
                    q_row.push_back(wr_row); q_col.push_back(wr_col);
                    q_vec.push_back(wr_vec); q_len.push_back(wr_cyc);
                    wr_cyc = 0;
                end
            end
            if (in_ready && (wr_en || mem_busy)) rdy_err++;
        end
    end

    task automatic clear_log();
        q_row.delete(); q_col.delete(); q_vec.delete(); q_len.delete();
        stab_err = 0; rdy_err = 0;
    endtask

    task automatic reset_dut();
        in_valid = 1'b0; in_last = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_log();
    endtask

    // Called at a negedge; returns at the negedge after the byte was consumed.
    task automatic send_byte(input logic [7:0] b, input bit last);
        bit ok = 1'b0;
        if (stuck) return;
        in_valid = 1'b1; in_data = b; in_last = last;
        for (int k = 0; k < 200; k++) begin
            if (in_ready) begin
                @(negedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        in_last = 1'b0;
        if (!ok) begin
            stuck = 1'b1;
            chk("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 2000; k++) begin
            if (done) break;
            @(negedge clock);
        end
        chk(tag, done, 1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [7:0] row,
                          input logic [7:0] col, input logic [15:0] vec);
        if (idx < q_vec.size()) begin
            chk({tag, "_row"}, q_row[idx], row);
            chk({tag, "_col"}, q_col[idx], col);
            chk({tag, "_vec"}, q_vec[idx], vec);
        end else begin
            chk({tag, "_missing"}, q_vec.size(), idx + 1);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_vec", wr_vec, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rows", rows_written, 0);

        // Single short row, in_last on the newline
        reset_dut();
        ack_dly = 1; busy_len = 0;
        send_str(".@@.\n", 1'b1);
        wait_done("t1_done");
        chk("t1_nwr", q_vec.size(), 1);
        chk_wr("t1_w0", 0, 8'd0, 8'd0, 16'h0006);
        chk("t1_rows", rows_written, 1);
        chk("t1_err", error, 0);

        // 20-cell row: full chunk goes out right after the 16th byte
        reset_dut();
        for (int i = 0; i < 16; i++) send_byte(8'h40, 1'b0);
        chk("t2_imm_wr", wr_en, 1);
        for (int i = 0; i < 4; i++) send_byte(8'h40, 1'b0);
        send_byte(8'd10, 1'b1);
        in_valid = 1'b0;
        wait_done("t2_done");
        chk("t2_nwr", q_vec.size(), 2);
        chk_wr("t2_w0", 0, 8'd0, 8'd0, 16'hFFFF);
        chk_wr("t2_w1", 1, 8'd0, 8'd16, 16'h000F);

        // Blank line and EOF without trailing newline
        reset_dut();
        send_str("@.\n\n.@", 1'b1);
        wait_done("t3_done");
        chk("t3_nwr", q_vec.size(), 2);
        chk_wr("t3_w0", 0, 8'd0, 8'd0, 16'h0001);
        chk_wr("t3_w1", 1, 8'd1, 8'd0, 16'h0002);
        chk("t3_rows", rows_written, 2);

        // Slow memory: ack after 5 cycles, busy 3 cycles after ack
        reset_dut();
        ack_dly = 5; busy_len = 3;
        send_str("@@@@@@@@@@@@@@@@@.\n", 1'b1);
        wait_done("t4_done");
        chk("t4_nwr", q_vec.size(), 2);
        chk_wr("t4_w0", 0, 8'd0, 8'd0, 16'hFFFF);
        chk_wr("t4_w1", 1, 8'd0, 8'd16, 16'h0001);
        if (q_len.size() > 0) chk("t4_wr_len", q_len[0], 5);
        else chk("t4_wr_len_missing", q_len.size(), 1);
        chk("t4_stable", stab_err, 0);
        chk("t4_ready_stall", rdy_err, 0);

        // Column overflow: 141 cells, then a second row
        reset_dut();
        ack_dly = 1; busy_len = 0;
        for (int i = 0; i < 141; i++) send_byte(8'h40, 1'b0);
        send_byte(8'd10, 1'b0);
        send_str("@\n", 1'b1);
        wait_done("t5_done");
        chk("t5_err", error, 1);
        chk("t5_nwr", q_vec.size(), 10);
        chk_wr("t5_w7", 7, 8'd0, 8'd112, 16'hFFFF);
        chk_wr("t5_w8", 8, 8'd0, 8'd128, 16'h0FFF);
        chk_wr("t5_w9", 9, 8'd1, 8'd0, 16'h0001);
        chk("t5_rows", rows_written, 2);

        // Reset while a write is outstanding
        reset_dut();
        send_str("@\n", 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (rows_written == 8'd1) break;
            @(negedge clock);
        end
        chk("t6_rows_pre", rows_written, 1);
        ack_en = 1'b0;
        send_str("@@\n", 1'b0);
        repeat (3) @(negedge clock);
        chk("t6_wr_held", wr_en, 1);
        chk("t6_vec_held", wr_vec, 16'h0003);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_wr_en", wr_en, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_rows", rows_written, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        reset = 1'b0;
        ack_en = 1'b1;
        clear_log();
        send_str(".@\n", 1'b1);
        wait_done("t6_done");
        chk("t6_nwr", q_vec.size(), 1);
        chk_wr("t6_w0", 0, 8'd0, 8'd0, 16'h0002);
        chk("t6_rows", rows_written, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/grid_row_packer.md
Name: grid_row_packer

Overview:
- Upstream load stage for the day-4 roll-grid engine.
- Consumes the puzzle input as an ASCII byte stream and packs each row into TX_DATA_WIDTH-bit partial vectors, with '@' = 1 and any other cell = 0.
- Issues one write packet per chunk to main memory using the memory's ack/busy handshake.
- Asserts done after the final row is committed, so the controller can raise run.

Parameters:
- TX_DATA_WIDTH, 16, bits per write chunk.
- MAX_COLS, 140, maximum cells per row.
- MAX_ROWS, 140, maximum rows accepted.
- BANK_ADDR_WIDTH, 8, row address width.
- COL_ADDR_WIDTH, 8, column address width.

Ports:
- clock  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  byte available.
- in_data  in  8  ASCII byte.
- in_last  in  1  byte is the final byte of the file.
- in_ready  out  1  packer accepts the byte this cycle.
- wr_en  out  1  write request to memory.
- wr_row  out  BANK_ADDR_WIDTH  row address.
- wr_col  out  COL_ADDR_WIDTH  chunk base column (a multiple of TX_DATA_WIDTH).
- wr_vec  out  TX_DATA_WIDTH  packed cells; bit i = column wr_col+i.
- mem_ack  in  1  memory accepted the write.
- mem_busy  in  1  memory still completing the previous access.
- done  out  1  sticky; all data written.
- error  out  1  sticky; overflow or dropped data.
- rows_written  out  BANK_ADDR_WIDTH  count of non-empty rows committed.

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_row=0, wr_col=0, wr_vec=0, done=0, error=0, rows_written=0. The column counter, row counter and pending vector are cleared.
- Reset is synchronous and takes effect mid-write as well: wr_en is low in the first cycle after the reset edge, and no partial state survives.

States:
- ACCEPT: in_ready=1. A byte is consumed on the edge where in_valid && in_ready.
- WRITE: wr_en=1, wr_row/wr_col/wr_vec held stable. Leave on the edge where mem_ack=1; wr_en drops the next cycle.
- DRAIN: wr_en=0. Wait until mem_busy=0, then go to ACCEPT, or to DONE if the EOF flag is set.
- DONE: in_ready=0, done=1. Stays here until reset.

Byte handling in ACCEPT:
- '\r' (13): ignored, no state change.
- '\n' (10):
  - If col%W != 0: flush the pending chunk at base floor(col/W)*W.
  - If col > 0: row++ and rows_written++ after the write commits.
  - col=0, pending vector cleared.
  - Empty line (col=0): no write, no row increment.
- Any other byte: vec[col%W] = (byte=="@"), col++.
  - If col%W becomes 0, the chunk is full: flush immediately at base col-W.
  - The byte is accepted in the same cycle it triggers WRITE.
- in_last on the consumed byte sets the EOF flag.
  - If the row is non-empty, it is flushed and counted as though '\n' followed.
  - After the last write drains, go to DONE.
  - in_last on a '\n' or '\r' needs no extra write.

Boundaries and errors:
- Column overflow: a non-newline byte with col == MAX_COLS is dropped and error is set; row assembly continues at the next '\n'.
- Row overflow: any data byte when row == MAX_ROWS is dropped and error is set; EOF still reaches DONE.
- wr_vec bits at and above col for the final partial chunk are 0.
- The flush vector is captured at the WRITE transition; the pending register is cleared in that same cycle.
- Unlimited wait on mem_ack or mem_busy; no timeout.
- Throughput is at most 1 byte/cycle in ACCEPT; each write costs ≥2 stall cycles.

Test Plan:
- Bytes ".@@.\n" with in_last on '\n', mem_ack returned 1 cycle after wr_en, mem_busy=0 → exactly one write: row 0, col 0, vec=0x0006; then rows_written=1, done=1, error=0.
- 20-cell row "@" × 20 + '\n' → write 1: row 0, col 0, vec=0xFFFF, issued right after the 16th byte; write 2: row 0, col 16, vec=0x000F.
- Two rows "@.\n\n.@" with in_last on the final '@', no trailing newline → writes (row 0, col 0, 0x0001) and (row 1, col 0, 0x0002); the blank line produces no write; rows_written=2, done=1.
- mem_ack delayed 5 cycles and mem_busy held 3 cycles after ack → wr_en and payload stable for all 5 cycles; in_ready=0 until mem_busy falls; no byte is lost while in_valid stays high.
- 141 '@' bytes + '\n' with MAX_COLS=140 → error=1; writes at cols 0..128, last vec=0x0FFF; the next row is still written to row 1.
- Reset asserted while wr_en=1 and mem_ack=0 → the next cycle shows wr_en=0, done=0, rows_written=0, in_ready=0; after reset releases, a new stream writes again from row 0.
